// File: rtl/mem_scratchpad_if.sv
// mem_scratchpad_if: request/response bundle between a core memory port and
// the scratchpad. res_err exists only when MEM_SCRATCHPAD_MISALIGN_ERR_EN is
// defined.
interface mem_scratchpad_if;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_fcn;
  logic [2:0]  req_typ;
  logic        req_valid;
  logic        req_ready;
  logic        res_valid;
  logic [31:0] res_data;
`ifdef MEM_SCRATCHPAD_MISALIGN_ERR_EN
  logic        res_err;
`endif

  // Requester side (core memory port).
  modport master (
    output req_addr, req_data, req_fcn, req_typ, req_valid,
    input  req_ready, res_valid, res_data
`ifdef MEM_SCRATCHPAD_MISALIGN_ERR_EN
    , input res_err
`endif
  );

  // Responder side (scratchpad).
  modport slave (
    input  req_addr, req_data, req_fcn, req_typ, req_valid,
    output req_ready, res_valid, res_data
`ifdef MEM_SCRATCHPAD_MISALIGN_ERR_EN
    , output res_err
`endif
  );
endinterface

// File: rtl/mem_scratchpad.sv
// mem_scratchpad: single-port, word-organised scratchpad memory with byte,
// halfword and word access, sign/zero extension and a fixed response latency
// of LATENCY+1 cycles after acceptance. One request outstanding at a time.
//
// Optional build macro: MEM_SCRATCHPAD_MISALIGN_ERR_EN
//   defined   -> res_err is driven; misaligned H/HU/W accesses write nothing,
//                return 0 and flag res_err with the response.
//   undefined -> no res_err; misaligned accesses are truncated to alignment.
module mem_scratchpad #(
  parameter int DEPTH_WORDS = 4096,  // power of two, >= 2
  parameter int LATENCY     = 1      // extra wait cycles, 0..15
) (
  input logic             clk,
  input logic             reset,     // asynchronous, active-low
  mem_scratchpad_if.slave bus
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  localparam logic [1:0] FCN_LOAD  = 2'd0;
  localparam logic [1:0] FCN_STORE = 2'd1;

  localparam logic [2:0] TYP_B  = 3'd1;
  localparam logic [2:0] TYP_H  = 3'd2;
  localparam logic [2:0] TYP_BU = 3'd5;
  localparam logic [2:0] TYP_HU = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        ready_q;
  logic        res_valid_q;
  logic [31:0] res_data_q;

  // Request fields captured at acceptance.
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_data;
  logic [1:0]    lat_fcn;
  logic [2:0]    lat_typ;

  logic [31:0] mem [DEPTH_WORDS];

  // Fields of the access performed at the edge entering RESP. With LATENCY=0
  // that edge is the acceptance edge itself, so the live request is used.
  logic          in_idle;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_data;
  logic [1:0]    acc_fcn;
  logic [2:0]    acc_typ;

  logic          accept;
  logic          enter_resp;

  logic [AW-1:0] idx;
  logic          is_byte;
  logic          is_half;
  logic          is_load;
  logic          is_store;
  logic          misalign;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ext;
  logic [31:0]   resp_data;
  logic          mem_we;

  // Address bits above the array size are ignored (addresses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];

  assign in_idle  = (state == IDLE);
  assign acc_addr = in_idle ? bus.req_addr[AW+1:0] : lat_addr;
  assign acc_data = in_idle ? bus.req_data         : lat_data;
  assign acc_fcn  = in_idle ? bus.req_fcn          : lat_fcn;
  assign acc_typ  = in_idle ? bus.req_typ          : lat_typ;

  assign accept     = ready_q && bus.req_valid;
  assign enter_resp = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == 4'd1));

  // Decode lanes, build the store write mask and the extended load result.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned; an unassigned path would infer a latch.
  always_comb begin
    idx      = acc_addr[AW+1:2];
    is_byte  = (acc_typ == TYP_B) || (acc_typ == TYP_BU);
    is_half  = (acc_typ == TYP_H) || (acc_typ == TYP_HU);
    is_load  = (acc_fcn == FCN_LOAD);
    is_store = (acc_fcn == FCN_STORE);
    be       = 4'b1111;
    wdata    = acc_data;
    if (is_byte) begin
      be    = 4'b0001 << acc_addr[1:0];
      wdata = {4{acc_data[7:0]}};
    end else if (is_half) begin
      be    = acc_addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{acc_data[15:0]}};
    end

    rword  = mem[idx];
    lane_b = rword[7:0];
    case (acc_addr[1:0])
      2'd1:    lane_b = rword[15:8];
      2'd2:    lane_b = rword[23:16];
      2'd3:    lane_b = rword[31:24];
      default: lane_b = rword[7:0];
    endcase
    lane_h = acc_addr[1] ? rword[31:16] : rword[15:0];

    ext = rword;
    case (acc_typ)
      TYP_B:   ext = {{24{lane_b[7]}}, lane_b};
      TYP_BU:  ext = {24'd0, lane_b};
      TYP_H:   ext = {{16{lane_h[15]}}, lane_h};
      TYP_HU:  ext = {16'd0, lane_h};
      default: ext = rword;
    endcase

    misalign = 1'b0;
`ifdef MEM_SCRATCHPAD_MISALIGN_ERR_EN
    misalign = (is_half && acc_addr[0]) ||
               (!is_byte && !is_half && (acc_addr[1:0] != 2'd0));
`endif

    resp_data = (is_load && !misalign) ? ext : 32'd0;
    // Requests presented while reset is asserted are outside the protocol;
    // the array itself is never gated by reset.
    mem_we    = enter_resp && is_store && !misalign;
  end

  // Byte-lane write into the array at the edge entering RESP.
  // NOTE: the array has no reset; clearing thousands of words is not a
  // single-cycle operation, and software never relies on initial contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Control FSM: accept, count the latency, emit a one-cycle response.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ready_q     <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= 32'd0;
      lat_addr    <= '0;
      lat_data    <= 32'd0;
      lat_fcn     <= 2'd0;
      lat_typ     <= 3'd0;
    end else begin
      if (accept) begin
        lat_addr <= bus.req_addr[AW+1:0];
        lat_data <= bus.req_data;
        lat_fcn  <= bus.req_fcn;
        lat_typ  <= bus.req_typ;
      end

      if (enter_resp) begin
        state       <= RESP;
        cnt         <= 4'd0;
        ready_q     <= 1'b0;
        res_valid_q <= 1'b1;
        res_data_q  <= resp_data;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state   <= WAIT;
              cnt     <= LAT;
              ready_q <= 1'b0;
            end
          end
          WAIT: begin
            cnt <= cnt - 4'd1;
          end
          RESP: begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
          end
          default: begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
          end
        endcase
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

`ifdef MEM_SCRATCHPAD_MISALIGN_ERR_EN
  logic res_err_q;
  logic resp_err;

  assign resp_err = (is_load || is_store) && misalign;

  // Error flag travels with the response pulse only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_err_q <= 1'b0;
    end else if (enter_resp) begin
      res_err_q <= resp_err;
    end else if (state == RESP) begin
      res_err_q <= 1'b0;
    end
  end

  assign bus.res_err = res_err_q;
`endif

endmodule

// File: tb/tb_mem_scratchpad.sv
// tb_mem_scratchpad: directed bench for mem_scratchpad. One instance runs with
// LATENCY=1 (main function), a second with LATENCY=4 (reset during WAIT).
module tb_mem_scratchpad;

  localparam logic [1:0] LD  = 2'd0;
  localparam logic [1:0] ST  = 2'd1;
  localparam logic [1:0] NOP = 2'd2;
  localparam logic [2:0] B   = 3'd1;
  localparam logic [2:0] H   = 3'd2;
  localparam logic [2:0] W   = 3'd3;
  localparam logic [2:0] BU  = 3'd5;
  localparam logic [2:0] HU  = 3'd6;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  mem_scratchpad_if bus1 ();
  mem_scratchpad_if bus4 ();

  mem_scratchpad #(.DEPTH_WORDS(4096), .LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus1)
  );

  mem_scratchpad #(.DEPTH_WORDS(4096), .LATENCY(4)) dut4 (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [1:0] fcn, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [31:0] data, input logic valid);
    if (sel) begin
      bus4.req_fcn = fcn; bus4.req_typ = typ; bus4.req_addr = addr;
      bus4.req_data = data; bus4.req_valid = valid;
    end else begin
      bus1.req_fcn = fcn; bus1.req_typ = typ; bus1.req_addr = addr;
      bus1.req_data = data; bus1.req_valid = valid;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus4.req_ready : bus1.req_ready;
  endfunction

  function automatic logic rvld(input bit sel);
    return sel ? bus4.res_valid : bus1.res_valid;
  endfunction

  function automatic logic rerr(input bit sel);
`ifdef MEM_SCRATCHPAD_MISALIGN_ERR_EN
    return sel ? bus4.res_err : bus1.res_err;
`else
    return sel ? 1'b0 : 1'b0;
`endif
  endfunction

  // One complete transaction with timing checks, then a data (and error) check.
  task automatic run(input bit sel, input logic [1:0] fcn, input logic [2:0] typ,
                     input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_data, input logic exp_err, input string tag);
    int          n;
    int          cyc;
    int          exp_cyc;
    logic        busy_ok;
    logic [31:0] rdata;
    logic        err;
    exp_cyc = sel ? 5 : 2;
    @(negedge clk);
    drive(sel, fcn, typ, addr, data, 1'b1);
    n = 0;
    while (!rdy(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready before accept"}, 32'(rdy(sel)), 32'd1);
    @(posedge clk);
    #1 drive(sel, 2'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    cyc     = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (rdy(sel)) busy_ok = 1'b0;
    end while (!rvld(sel) && cyc < 40);
    rdata = sel ? bus4.res_data : bus1.res_data;
    err   = rerr(sel);
    check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " ready low while busy"}, 32'(busy_ok), 32'd1);
    check({tag, " data"}, rdata, exp_data);
`ifdef MEM_SCRATCHPAD_MISALIGN_ERR_EN
    check({tag, " err"}, 32'(err), 32'(exp_err));
`else
    if (err !== 1'b0 || exp_err !== 1'b0) check({tag, " err"}, 32'(err), 32'(exp_err));
`endif
    @(negedge clk);
    check({tag, " pulse ends, ready back"}, {30'd0, rvld(sel), rdy(sel)}, 32'd1);
  endtask

  initial begin
    int nvalid;
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 2'd0, 3'd0, 32'd0, 32'd0, 1'b0);

    // Reset values.
    #12;
    check("reset req_ready",  32'(bus1.req_ready), 32'd1);
    check("reset res_valid",  32'(bus1.res_valid), 32'd0);
    check("reset res_data",   bus1.res_data,       32'd0);
    check("reset4 req_ready", 32'(bus4.req_ready), 32'd1);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle res_valid", 32'(bus1.res_valid), 32'd0);
    end

    // Word store/load.
    run(1'b0, ST, W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st W 0x10");
    run(1'b0, LD, W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld W 0x10");

    // Byte store into lane 3, loads with both extensions.
    run(1'b0, ST, W,  32'h10, 32'h11223344, 32'h0, 1'b0, "st W 0x10 base");
    run(1'b0, ST, B,  32'h13, 32'hABCDEF80, 32'h0, 1'b0, "st B 0x13");
    run(1'b0, LD, W,  32'h10, 32'h0, 32'h80223344, 1'b0, "ld W after st B");
    run(1'b0, LD, B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "ld B 0x13");
    run(1'b0, LD, BU, 32'h13, 32'h0, 32'h00000080, 1'b0, "ld BU 0x13");
    run(1'b0, LD, B,  32'h10, 32'h0, 32'h00000044, 1'b0, "ld B 0x10");
    run(1'b0, LD, BU, 32'h12, 32'h0, 32'h00000022, 1'b0, "ld BU 0x12");

    // Halfword store into the upper half.
    run(1'b0, ST, W,  32'h20, 32'h12345678, 32'h0, 1'b0, "st W 0x20 base");
    run(1'b0, ST, H,  32'h22, 32'h9999BEEF, 32'h0, 1'b0, "st H 0x22");
    run(1'b0, LD, HU, 32'h22, 32'h0, 32'h0000BEEF, 1'b0, "ld HU 0x22");
    run(1'b0, LD, H,  32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, "ld H 0x22");
    run(1'b0, LD, W,  32'h20, 32'h0, 32'hBEEF5678, 1'b0, "ld W 0x20");
    run(1'b0, LD, H,  32'h20, 32'h0, 32'h00005678, 1'b0, "ld H 0x20");

    // Address wrap and no-op.
    run(1'b0, ST, W,  32'h4000, 32'h5, 32'h0, 1'b0, "st W 0x4000");
    run(1'b0, LD, W,  32'h0, 32'h0, 32'h5, 1'b0, "ld W 0x0 wrap");
    run(1'b0, NOP, W, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0, "nop fcn2");
    run(1'b0, 2'd3, B, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b0, "nop fcn3");
    run(1'b0, LD, W,  32'h10, 32'h0, 32'h80223344, 1'b0, "ld W after nop");

`ifdef MEM_SCRATCHPAD_MISALIGN_ERR_EN
    // Misaligned accesses are rejected.
    run(1'b0, LD, W,  32'h2,  32'h0, 32'h0, 1'b1, "ld W 0x2 misaligned");
    run(1'b0, LD, HU, 32'h21, 32'h0, 32'h0, 1'b1, "ld HU 0x21 misaligned");
    run(1'b0, ST, H,  32'h23, 32'h00007777, 32'h0, 1'b1, "st H 0x23 misaligned");
    run(1'b0, LD, W,  32'h20, 32'h0, 32'hBEEF5678, 1'b0, "ld W 0x20 unchanged");
`else
    // Misaligned accesses truncate to alignment.
    run(1'b0, LD, HU, 32'h21, 32'h0, 32'h00005678, 1'b0, "ld HU 0x21 truncated");
    run(1'b0, LD, W,  32'h12, 32'h0, 32'h80223344, 1'b0, "ld W 0x12 truncated");
    run(1'b0, ST, H,  32'h23, 32'h00007777, 32'h0, 1'b0, "st H 0x23 truncated");
    run(1'b0, LD, W,  32'h20, 32'h0, 32'h77775678, 1'b0, "ld W 0x20 after st H");
`endif

    // LATENCY=4: reset during WAIT drops the pending store.
    run(1'b1, ST, W, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, "L4 st W 0x8");
    @(negedge clk);
    drive(1'b1, ST, W, 32'h8, 32'h1, 1'b1);
    check("L4 ready before accept", 32'(bus4.req_ready), 32'd1);
    @(posedge clk);
    #1 drive(1'b1, 2'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_b = 1'b0;
    nvalid = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.res_valid) nvalid++;
    end
    check("L4 no response after reset", 32'(nvalid), 32'd0);
    check("L4 ready in reset", 32'(bus4.req_ready), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    run(1'b1, LD, W, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, "L4 ld W 0x8 prior");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_scratchpad.md
Name: mem_scratchpad

Overview:
- Single-port word-organised scratchpad memory; sits directly downstream of the core's imem or dmem port and consumes its flattened MemoryIn request fields, producing MemoryOut response fields.
- Instantiated twice in the test harness, once for the instruction port and once for the data port.
- Supports byte, halfword and word loads and stores with sign/zero extension and a configurable fixed response latency.
- One outstanding request at a time.

Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; power of two, ≥ 2.
- LATENCY, 1: extra wait cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset: 0 = in reset.
- req_addr  input  32  byte address.
- req_data  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- req_fcn  input  2  0 = load, 1 = store, 2/3 = no-op.
- req_typ  input  3  1 = B, 2 = H, 3 = W, 5 = BU, 6 = HU; other codes treated as W.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- res_valid  output  1  one-cycle response pulse.
- res_data  output  32  load result; 0 for store and no-op.

Behaviour:
- Reset values:
  - state = IDLE
  - req_ready = 1
  - res_valid = 0
  - res_data = 0
  - wait counter = 0
  - memory array contents are not reset.
- Reset is asynchronous: asserting it mid-operation aborts any pending access, and no response is produced for it. A store that was accepted but not yet written is dropped.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- States:
  - IDLE: req_ready = 1. When req_valid & req_ready at an edge, latch addr/data/fcn/typ. Go to WAIT with counter = LATENCY if LATENCY > 0, else go to RESP.
  - WAIT: req_ready = 0. Decrement the counter each cycle; when the counter reaches 1, go to RESP.
  - RESP: req_ready = 0, res_valid = 1 for exactly one cycle, then go to IDLE.
  - Response cycle = accept edge + LATENCY + 1 cycles.
  - Back-to-back spacing: a new request can be accepted no earlier than the edge ending RESP + 1 (i.e., in the cycle after the res_valid pulse).
- Memory access happens at the edge entering RESP. Store writes and load data capture both occur there; res_data is registered.
- Byte lanes:
  - B/BU use addr[1:0].
  - H/HU use addr[1]; addr[0] is ignored, i.e. truncated alignment.
  - W ignores addr[1:0].
- Store updates only the selected lanes; other bytes of the word are unchanged.
- Load extension: B and H sign-extend; BU and HU zero-extend; W passes through unchanged.
- req_valid while not ready is ignored, with no side effects. The requester must hold the request until it is accepted.
- No-op fcn: handshake and response timing are identical to a load; res_data = 0; memory is unchanged.

Optional Feature:
- Macro: MEM_SCRATCHPAD_MISALIGN_ERR_EN.
- When defined:
  - Adds output res_err (1 bit, reset 0), valid only with res_valid.
  - A misaligned access (H/HU with addr[0] = 1, W with addr[1:0] ≠ 0) performs no write, returns res_data = 0 and res_err = 1.
  - Timing is unchanged.
- When not defined: no res_err port; misaligned accesses are truncated as described in Behaviour.

Test Plan:
- Reset then idle (LATENCY = 1): reset = 0 → req_ready = 1, res_valid = 0, res_data = 0; hold reset = 1 for 5 idle cycles → no res_valid.
- Word store 0xDEADBEEF @0x10, then word load @0x10:
  - load returns 0xDEADBEEF.
  - res_valid is exactly 2 cycles after each accept.
  - req_ready = 0 from accept through the RESP cycle.
- Byte store 0x80 @0x13 over 0x11223344, then:
  - W load → 0x80223344.
  - B load @0x13 → 0xFFFFFF80.
  - BU load @0x13 → 0x00000080.
- H store 0xBEEF @0x22, then:
  - HU load @0x22 → 0x0000BEEF.
  - H load → 0xFFFFBEEF.
  - W load @0x20 → 0xBEEFxxxx, where the low half is unchanged.
- Wrap and no-op (DEPTH_WORDS = 4096):
  - store 0x5 @0x4000, then load @0x0 → 0x5.
  - fcn = 2 → res_valid pulse with res_data = 0 and memory unchanged.
- Reset mid-WAIT (LATENCY = 4): accept a store 0x1 @0x8, assert reset 2 cycles later → no res_valid; after release, load @0x8 returns the prior contents.
- With the macro defined: W load @0x2 → res_err = 1, res_data = 0.
